// File: rtl/fsm_4.sv
// ---------------------------------------------------------------------------
// fsm_4
//
// Read-channel controller for a simple AXI-style slave whose read data comes
// from one of four output FIFOs. One read address is accepted at a time. Its
// ID is echoed on every data beat. Address bits [9:8] pick the FIFO to drain.
// The burst length sets how many words are popped from that FIFO. Every burst
// is treated as FIXED, so arsize and arburst are accepted but not used.
//
// Ports
//   clk               clock; all state changes on the rising edge
//   reset             synchronous, active-high reset
//   axs_s0_arid       read address ID (latched on acceptance)
//   axs_s0_araddr     read address; bits [9:8] select the FIFO
//   axs_s0_arlen      burst length minus one
//   axs_s0_arsize     beat size (unused)
//   axs_s0_arburst    burst type (unused)
//   axs_s0_arvalid    master read-address valid
//   axs_s0_rready     master ready for read data
//   out_fifo_empty    selected output FIFO is empty
//   axs_s0_arready    slave ready for a read address
//   axs_s0_rid        read data ID (held from acceptance to next acceptance)
//   axs_s0_rlast      last beat of the current burst
//   axs_s0_rvalid     read data valid
//   out_fifo_pop      pop one word from the selected FIFO
//   out_fifo_pop_sel  FIFO select (held from acceptance to next acceptance)
// ---------------------------------------------------------------------------
module fsm_4 (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  axs_s0_arid,
    input  logic [31:0] axs_s0_araddr,
    input  logic [7:0]  axs_s0_arlen,
    input  logic [2:0]  axs_s0_arsize,
    input  logic [1:0]  axs_s0_arburst,
    input  logic        axs_s0_arvalid,
    input  logic        axs_s0_rready,
    input  logic        out_fifo_empty,
    output logic        axs_s0_arready,
    output logic [3:0]  axs_s0_rid,
    output logic        axs_s0_rlast,
    output logic        axs_s0_rvalid,
    output logic        out_fifo_pop,
    output logic [1:0]  out_fifo_pop_sel
);

    typedef enum logic [2:0] {
        INIT,
        AR_READY,
        OF_EMPTY,
        MASTER_WAIT,
        R_VALID,
        R_VALID_LAST
    } state_t;

    state_t     state;
    logic [3:0] rid_reg;
    logic [1:0] sel_reg;
    // Nine bits let arlen = 255 load 256 without wrapping to zero.
    logic [8:0] beat_count;
    logic       arready_reg;
    logic       rlast_reg;

    logic       data_phase;
    logic       beat;

    // These address and attribute bits do not affect FIFO draining. Folding
    // them into one net documents that they are ignored on purpose.
    logic       unused_inputs;
    assign unused_inputs = ^{axs_s0_araddr[31:10], axs_s0_araddr[7:0],
                             axs_s0_arsize, axs_s0_arburst};

    // rvalid follows FIFO occupancy combinationally. A FIFO that empties
    // mid-burst therefore stalls the beat in the same cycle, and no word is
    // popped or skipped. Gating with reset keeps the reset cycle free of pops
    // even when reset cuts into a burst.
    assign data_phase     = (state == R_VALID) || (state == R_VALID_LAST);
    assign axs_s0_rvalid  = data_phase && !out_fifo_empty && !reset;
    assign beat           = axs_s0_rvalid && axs_s0_rready;
    assign out_fifo_pop   = beat;

    assign axs_s0_arready   = arready_reg;
    assign axs_s0_rlast     = rlast_reg;
    assign axs_s0_rid       = rid_reg;
    assign out_fifo_pop_sel = sel_reg;

    // Main controller. arready and rlast are registered. Each is set on the
    // edge that enters, or stays in, the one state where it must be high. It
    // then matches the state decode without a combinational path. The beat
    // counter holds the number of beats still owed. A beat that takes the
    // counter from 2 to 1 moves the FSM to R_VALID_LAST. A burst of length 1
    // goes straight there from MASTER_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT;
            rid_reg     <= 4'd0;
            sel_reg     <= 2'd0;
            beat_count  <= 9'd0;
            arready_reg <= 1'b0;
            rlast_reg   <= 1'b0;
        end else begin
            arready_reg <= 1'b0;
            rlast_reg   <= 1'b0;
            case (state)
                INIT: begin
                    state       <= AR_READY;
                    arready_reg <= 1'b1;
                end

                AR_READY: begin
                    if (axs_s0_arvalid) begin
                        rid_reg    <= axs_s0_arid;
                        sel_reg    <= axs_s0_araddr[9:8];
                        beat_count <= {1'b0, axs_s0_arlen} + 9'd1;
                        state      <= OF_EMPTY;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end

                OF_EMPTY: begin
                    if (!out_fifo_empty) begin
                        state <= MASTER_WAIT;
                    end
                end

                MASTER_WAIT: begin
                    if (axs_s0_rready) begin
                        if (beat_count == 9'd1) begin
                            state     <= R_VALID_LAST;
                            rlast_reg <= 1'b1;
                        end else begin
                            state <= R_VALID;
                        end
                    end
                end

                R_VALID: begin
                    if (beat) begin
                        beat_count <= beat_count - 9'd1;
                        if (beat_count == 9'd2) begin
                            state     <= R_VALID_LAST;
                            rlast_reg <= 1'b1;
                        end
                    end
                end

                R_VALID_LAST: begin
                    if (beat) begin
                        beat_count  <= beat_count - 9'd1;
                        state       <= AR_READY;
                        arready_reg <= 1'b1;
                    end else begin
                        rlast_reg <= 1'b1;
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_4.sv
// ---------------------------------------------------------------------------
// tb_fsm_4
//
// Directed bench for fsm_4. Each accepted read request pushes its expected
// beats (rid, FIFO select, last flag) into a queue. A free-running monitor
// pops one entry for every rvalid/rready handshake and compares it. Stimulus
// tasks also check handshake outputs at fixed points and count pops per burst.
// ---------------------------------------------------------------------------
module tb_fsm_4;

    logic        clk;
    logic        reset;
    logic [3:0]  axs_s0_arid;
    logic [31:0] axs_s0_araddr;
    logic [7:0]  axs_s0_arlen;
    logic [2:0]  axs_s0_arsize;
    logic [1:0]  axs_s0_arburst;
    logic        axs_s0_arvalid;
    logic        axs_s0_rready;
    logic        out_fifo_empty;
    logic        axs_s0_arready;
    logic [3:0]  axs_s0_rid;
    logic        axs_s0_rlast;
    logic        axs_s0_rvalid;
    logic        out_fifo_pop;
    logic [1:0]  out_fifo_pop_sel;

    typedef struct {
        logic [3:0] rid;
        logic [1:0] sel;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    fsm_4 dut (
        .clk              (clk),
        .reset            (reset),
        .axs_s0_arid      (axs_s0_arid),
        .axs_s0_araddr    (axs_s0_araddr),
        .axs_s0_arlen     (axs_s0_arlen),
        .axs_s0_arsize    (axs_s0_arsize),
        .axs_s0_arburst   (axs_s0_arburst),
        .axs_s0_arvalid   (axs_s0_arvalid),
        .axs_s0_rready    (axs_s0_rready),
        .out_fifo_empty   (out_fifo_empty),
        .axs_s0_arready   (axs_s0_arready),
        .axs_s0_rid       (axs_s0_rid),
        .axs_s0_rlast     (axs_s0_rlast),
        .axs_s0_rvalid    (axs_s0_rvalid),
        .out_fifo_pop     (out_fifo_pop),
        .out_fifo_pop_sel (out_fifo_pop_sel)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop in case a task's own cycle bounds are bypassed somehow.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllOutputs(input string tag, input logic arready,
                                   input logic [3:0] rid, input logic [1:0] sel);
        checkOutput({tag, " arready"}, 32'(axs_s0_arready), 32'(arready));
        checkOutput({tag, " rid"},     32'(axs_s0_rid),     32'(rid));
        checkOutput({tag, " pop_sel"}, 32'(out_fifo_pop_sel), 32'(sel));
        checkOutput({tag, " rvalid"},  32'(axs_s0_rvalid),  32'd0);
        checkOutput({tag, " rlast"},   32'(axs_s0_rlast),   32'd0);
        checkOutput({tag, " pop"},     32'(out_fifo_pop),   32'd0);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the edge that
    // moves the DUT.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_fifo_empty) begin
                    checkOutput("rvalid while fifo empty", 32'(axs_s0_rvalid), 32'd0);
                    checkOutput("pop while fifo empty", 32'(out_fifo_pop), 32'd0);
                end else if (!axs_s0_rready) begin
                    checkOutput("pop without rready", 32'(out_fifo_pop), 32'd0);
                end
                if (axs_s0_rvalid && axs_s0_rready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("[TB] FAIL unexpected beat: rid %0h with empty scoreboard",
                                 axs_s0_rid);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat rid", 32'(axs_s0_rid), 32'(b.rid));
                        checkOutput("beat pop_sel", 32'(out_fifo_pop_sel), 32'(b.sel));
                        checkOutput("beat rlast", 32'(axs_s0_rlast), 32'(b.last));
                        checkOutput("beat pop", 32'(out_fifo_pop), 32'd1);
                    end
                end
            end
        end
    end

    // Issues one read address. On entry the bench sits at a falling edge with
    // the DUT expected to be in AR_READY. On exit it sits at the falling edge
    // after acceptance.
    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len);
        int waited = 0;
        while (!axs_s0_arready && waited < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        checkOutput("arready before request", 32'(axs_s0_arready), 32'd1);
        @(posedge clk); #1;
        axs_s0_arid    = id;
        axs_s0_araddr  = addr;
        axs_s0_arlen   = len;
        axs_s0_arsize  = 3'd2;
        axs_s0_arburst = 2'd1;
        axs_s0_arvalid = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back('{rid: id, sel: addr[9:8], last: (i == int'(len))});
        end
        @(posedge clk); #1;
        axs_s0_arvalid = 1'b0;
        @(negedge clk);
        checkOutput("arready after accept", 32'(axs_s0_arready), 32'd0);
        checkOutput("rid after accept", 32'(axs_s0_rid), 32'(id));
        checkOutput("pop_sel after accept", 32'(out_fifo_pop_sel), 32'(addr[9:8]));
    endtask

    // Runs until arready returns, counting pops. It can optionally starve the
    // FIFO for stall_len cycles once stall_after beats have been seen.
    task automatic runBurst(input string tag, input int exp_beats,
                            input int stall_after, input int stall_len);
        int  pops    = 0;
        int  first   = -1;
        int  last    = -1;
        bit  done    = 1'b0;
        bit  stalled = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (out_fifo_pop) begin
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            if (axs_s0_arready) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (!stalled && pops == stall_after) begin
                    stalled = 1'b1;
                    out_fifo_empty = 1'b1;
                    repeat (stall_len) begin
                        @(negedge clk);
                        checkOutput({tag, " stall rvalid"}, 32'(axs_s0_rvalid), 32'd0);
                        checkOutput({tag, " stall pop"}, 32'(out_fifo_pop), 32'd0);
                        @(posedge clk); #1;
                    end
                    out_fifo_empty = 1'b0;
                end
            end
        end
        checkOutput({tag, " completed"}, 32'(done), 32'd1);
        checkOutput({tag, " pop count"}, 32'(pops), 32'(exp_beats));
        if (stall_after < 0) begin
            checkOutput({tag, " consecutive pops"}, 32'(last - first), 32'(exp_beats - 1));
        end
    endtask

    initial begin
        int c;
        reset          = 1'b1;
        axs_s0_arid    = 4'd0;
        axs_s0_araddr  = 32'd0;
        axs_s0_arlen   = 8'd0;
        axs_s0_arsize  = 3'd0;
        axs_s0_arburst = 2'd0;
        axs_s0_arvalid = 1'b0;
        axs_s0_rready  = 1'b0;
        out_fifo_empty = 1'b1;

        // Two reset edges, then one cycle in INIT, then AR_READY.
        @(posedge clk); #1;
        @(negedge clk);
        checkAllOutputs("in reset", 1'b0, 4'd0, 2'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkAllOutputs("init cycle", 1'b0, 4'd0, 2'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkAllOutputs("first ar_ready", 1'b1, 4'd0, 2'd0);

        // Burst of 4 from FIFO 3, with FIFO empty for 3 cycles first. A
        // stray arvalid during OF_EMPTY must not be taken.
        $display("[TB] burst id 5, arlen 3, fifo 3");
        applyStimulus(4'd5, 32'h0000_3F00, 8'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                axs_s0_arid    = 4'hA;
                axs_s0_araddr  = 32'h0000_0100;
                axs_s0_arlen   = 8'd9;
                axs_s0_arvalid = 1'b1;
            end
            if (i == 2) axs_s0_arvalid = 1'b0;
            @(negedge clk);
            checkAllOutputs("of_empty wait", 1'b0, 4'd5, 2'd3);
        end
        @(posedge clk); #1;
        out_fifo_empty = 1'b0;
        axs_s0_rready  = 1'b1;
        runBurst("burst4", 4, -1, 0);
        checkAllOutputs("after burst4", 1'b1, 4'd5, 2'd3);

        // Single-beat burst: rlast on the only beat.
        $display("[TB] burst id 6, arlen 0, fifo 1");
        applyStimulus(4'd6, 32'h0000_0100, 8'd0);
        runBurst("burst1", 1, -1, 0);

        // Five beats with a two-cycle FIFO underrun after the second beat.
        $display("[TB] burst id 9, arlen 4, mid-burst stall");
        applyStimulus(4'd9, 32'h0000_0200, 8'd4);
        runBurst("stall burst", 5, 2, 2);

        // Longest burst: arlen 255 gives 256 beats.
        $display("[TB] burst id F, arlen 255");
        applyStimulus(4'hF, 32'h1234_5600, 8'd255);
        runBurst("burst256", 256, -1, 0);

        // Reset during R_VALID aborts the burst.
        $display("[TB] reset in the middle of a burst");
        applyStimulus(4'd3, 32'h0000_0300, 8'd7);
        c = 0;
        do begin
            @(posedge clk); #1;
            @(negedge clk);
            c++;
        end while (!out_fifo_pop && c < 20);
        checkOutput("first pop before reset", 32'(out_fifo_pop), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("reset cycle pop", 32'(out_fifo_pop), 32'd0);
        checkOutput("reset cycle rvalid", 32'(axs_s0_rvalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkAllOutputs("init after mid-burst reset", 1'b0, 4'd0, 2'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkAllOutputs("ar_ready after mid-burst reset", 1'b1, 4'd0, 2'd0);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
